// File: rtl/serial_addsub_pkg.sv
// Shared types for the serial add/subtract datapath.
// No logic; state encoding only.
// No flow control.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple adder built from full_adder1b cells.
// Combinational, zero cycles.
// No flow control; also exposes the carry into the top cell.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] sum,
    output logic             co,
    output logic             c_top
);

    // Carries live in per-cell nets so the chain is never one self-dependent vector.
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        logic cin_i;
        logic cout_i;
        if (i == 0) begin : g_first
            assign cin_i = ci;
        end else begin : g_next
            assign cin_i = g_fa[i-1].cout_i;
        end
        full_adder1b u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (cin_i),
            .sum  (sum[i]),
            .cout (cout_i)
        );
    end

    assign co    = g_fa[DIGIT-1].cout_i;
    assign c_top = g_fa[DIGIT-1].cin_i;

endmodule

// File: rtl/full_adder1b.sv
// One-bit full adder cell.
// Combinational, zero cycles.
// No flow control.
module full_adder1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Serial add/subtract, DIGIT bits per cycle LSB first, WIDTH/DIGIT steps.
// Latency: done pulses STEPS+1 cycles after start is accepted.
// start is ignored while busy; results hold until the next done.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             OVF
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_param_check
        $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_e              state;
    logic [WIDTH-1:0]    a_sh;
    logic [WIDTH-1:0]    b_sh;
    logic [WIDTH-1:0]    s_sh;
    logic                carry;
    logic [SW-1:0]       step;

    logic [DIGIT-1:0]        sum_dig;
    logic                    co_dig;
    logic                    c_top;
    logic [WIDTH+DIGIT-1:0]  s_cat;
    logic [WIDTH-1:0]        s_next;
    logic                    last_step;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a     (a_sh[DIGIT-1:0]),
        .b     (b_sh[DIGIT-1:0]),
        .ci    (carry),
        .sum   (sum_dig),
        .co    (co_dig),
        .c_top (c_top)
    );

    // New digit enters at the top; after STEPS shifts the LSB digit sits at bit 0.
    assign s_cat     = {sum_dig, s_sh};
    assign s_next    = s_cat[WIDTH+DIGIT-1:DIGIT];
    assign last_step = (step == SW'(STEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            step  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtract is A + ~B + 1, so Cout reads as "no borrow".
                        a_sh  <= A;
                        b_sh  <= SUB ? ~B : B;
                        carry <= SUB ? 1'b1 : Cin;
                        step  <= '0;
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    s_sh  <= s_next;
                    carry <= co_dig;
                    step  <= step + SW'(1);
                    if (last_step) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        S     <= s_next;
                        Cout  <= co_dig;
                        OVF   <= co_dig ^ c_top;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: five instances (8/1, 8/4, 4/1, 4/2, 4/4) driven one at a time.
module tb_serial_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] start_v;
    logic       sub;
    logic       cin;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [4:0] busy_v;
    logic [4:0] done_v;
    logic [4:0] cout_v;
    logic [4:0] ovf_v;
    logic [7:0] s_v [5];
    logic [3:0] s4  [3];

    int n_cmp = 0;
    int n_bad = 0;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .SUB(sub), .A(a8), .B(b8), .Cin(cin),
        .busy(busy_v[0]), .done(done_v[0]), .S(s_v[0]), .Cout(cout_v[0]), .OVF(ovf_v[0]));

    serial_addsub #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .SUB(sub), .A(a8), .B(b8), .Cin(cin),
        .busy(busy_v[1]), .done(done_v[1]), .S(s_v[1]), .Cout(cout_v[1]), .OVF(ovf_v[1]));

    for (genvar k = 0; k < 3; k++) begin : g_w4
        serial_addsub #(.WIDTH(4), .DIGIT(1 << k)) u_w4 (
            .clk(clk), .rst_n(rst_n), .start(start_v[k+2]), .SUB(sub), .A(a8[3:0]), .B(b8[3:0]),
            .Cin(cin), .busy(busy_v[k+2]), .done(done_v[k+2]), .S(s4[k]), .Cout(cout_v[k+2]),
            .OVF(ovf_v[k+2]));
        assign s_v[k+2] = {4'h0, s4[k]};
    end

    typedef struct {
        int         sel;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       su;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t tbl [8];

    function automatic int steps_of(input int sel);
        case (sel)
            0:       return 8;
            1:       return 2;
            2:       return 4;
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int width_of(input int sel);
        return (sel < 2) ? 8 : 4;
    endfunction

    // Reference: plain integer arithmetic; OVF from the signed result leaving the signed range.
    function automatic logic [9:0] ref_op(input int w, input int a, input int b,
                                          input bit ci, input bit su);
        int  half;
        int  sa;
        int  sb;
        int  full;
        int  r;
        bit  co;
        bit  ov;
        half = 1 << (w - 1);
        sa   = (a >= half) ? a - 2 * half : a;
        sb   = (b >= half) ? b - 2 * half : b;
        if (su) begin
            full = a - b;
            co   = (a >= b);
            r    = sa - sb;
        end else begin
            full = a + b + int'(ci);
            co   = ((full >> w) & 1) == 1;
            r    = sa + sb + int'(ci);
        end
        ov = (r < -half) || (r > half - 1);
        return {ov, co, 8'(full & (2 * half - 1))};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle so calls chain back-to-back.
    task automatic do_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic su, input bit poke,
                         output logic [7:0] s, output logic co, output logic ov);
        int         st;
        int         perr;
        logic [7:0] s0;
        st   = steps_of(sel);
        perr = 0;
        s0   = s_v[sel];
        a8   = a;
        b8   = b;
        cin  = ci;
        sub  = su;
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_v = '0;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
        for (int c = 1; c <= st + 1; c++) begin
            @(negedge clk);
            if (busy_v[sel] !== (c <= st) || done_v[sel] !== (c == st + 1)) perr++;
            if (c <= st && s_v[sel] !== s0) perr++;
            if (c <= st) start_v[sel] = poke && (c == 2);
        end
        s  = s_v[sel];
        co = cout_v[sel];
        ov = ovf_v[sel];
        chk($sformatf("handshake sel%0d", sel), 32'(perr), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s;
        logic       co;
        logic       ov;
        logic [9:0] r;
        int         cnt;

        tbl[0] = '{0, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        tbl[1] = '{0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[2] = '{0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[3] = '{1, 8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[4] = '{0, 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
        tbl[5] = '{1, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[6] = '{0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[7] = '{1, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

        start_v = '0;
        sub = 1'b0;
        cin = 1'b0;
        a8  = '0;
        b8  = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("reset flags sel%0d", i),
                32'({busy_v[i], done_v[i], cout_v[i], ovf_v[i]}), 32'd0);
            chk($sformatf("reset S sel%0d", i), 32'(s_v[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Get a nonzero held result, then abandon an operation mid-run with reset.
        do_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, s, co, ov);
        chk("pre-reset S", 32'(s), 32'h80);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; cin = 1'b1; sub = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun reset busy", 32'(busy_v[0]), 32'd0);
        chk("midrun reset done", 32'(done_v[0]), 32'd0);
        chk("midrun reset S", 32'(s_v[0]), 32'd0);
        chk("midrun reset Cout", 32'(cout_v[0]), 32'd0);
        chk("midrun reset OVF", 32'(ovf_v[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) cnt++;
        end
        chk("no done after reset", 32'(cnt), 32'd0);

        // Directed vectors, issued back-to-back (each start lands in the previous DONE cycle).
        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].su, 1'b0, s, co, ov);
            chk($sformatf("tbl%0d S", i), 32'(s), 32'(tbl[i].s));
            chk($sformatf("tbl%0d Cout", i), 32'(co), 32'(tbl[i].co));
            chk($sformatf("tbl%0d OVF", i), 32'(ov), 32'(tbl[i].ov));
        end

        // start pulsed mid-run with scrambled operands must be dropped, not queued.
        @(negedge clk);
        do_op(0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1, s, co, ov);
        chk("poke S", 32'(s), 32'h46);
        chk("poke Cout/OVF", 32'({co, ov}), 32'd0);
        @(negedge clk);
        chk("poke not queued", 32'({busy_v[0], done_v[0]}), 32'd0);
        repeat (3) @(negedge clk);
        chk("idle hold S", 32'(s_v[0]), 32'h46);

        // Exhaustive 4-bit sweep for DIGIT = 1, 2, 4.
        for (int sel = 2; sel < 5; sel++) begin
            cnt = n_bad;
            for (int v = 0; v < 1024; v++) begin
                do_op(sel, 8'(v & 15), 8'((v >> 4) & 15), v[8], v[9], 1'b0, s, co, ov);
                r = ref_op(4, v & 15, (v >> 4) & 15, v[8], v[9]);
                chk($sformatf("sweep sel%0d v%0d", sel, v), 32'({ov, co, s}), 32'(r));
            end
        end

        // Random 8-bit operations on both 8-bit instances.
        for (int i = 0; i < 200; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            logic       rs;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            do_op(i % 2, ra, rb, rc, rs, 1'b0, s, co, ov);
            r = ref_op(width_of(i % 2), int'(ra), int'(rb), rc, rs);
            chk($sformatf("rand%0d sel%0d", i, i % 2), 32'({ov, co, s}), 32'(r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
